box_downsampler: RTL
====================

Name: box_downsampler

Overview:
- Streaming 2x2 box-filter decimator. It is the inverse direction of the 2-bit to 4-bit bilinear upscaler.
- Consumes a raster-order stream of 4-bit grey pixels (IN_W x IN_H) and emits a raster-order stream of 2-bit pixels (IN_W/2 x IN_H/2).
- Sits between the camera/canvas capture path and the 2-bit digit buffer on the DE10 board.
- Valid/ready handshake on both sides; one internal line buffer of partial sums.

Parameters:
- IN_W, 32, input line width in pixels; even, >= 2.
- IN_H, 32, input frame height in lines; even, >= 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept an input pixel this cycle.
- in_pix  in  4  input pixel value, 0..15.
- in_sof  in  1  start of frame; qualifies the current beat as pixel (0,0).
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts the output pixel.
- out_pix  out  2  decimated pixel.
- out_last  out  1  marks the final output pixel of a frame (x=IN_W/2-1, y=IN_H/2-1).

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_pix=0, out_last=0. Column/row counters=0. Pair register=0. Line buffer contents are don't-care, because row 0 always overwrites them before they are read.
- Input accept: beat = in_valid & in_ready.
- in_ready = !(out_valid & !out_ready). Stall only while the output register is occupied and not draining. The output register is single-entry.
- Counters: col 0..IN_W-1, row 0..IN_H-1. Advance on each beat. col wraps to 0 and increments row; row wraps to 0 after IN_H-1.
- in_sof on a beat forces that beat to be processed as col=0,row=0. Counters then continue from (1,0). Any partial frame in progress is abandoned. A pending output in the output register is still delivered unchanged. in_sof on a non-beat cycle is ignored.
- Even col: pair register <= in_pix.
- Odd col, even row: linebuf[col>>1] <= pair + in_pix (5-bit, max 30). No output.
- Odd col, odd row:
  - sum = linebuf[col>>1] + pair + in_pix (6-bit, max 60).
  - avg = (sum + 2) >> 2 (4-bit, max 15; no saturation needed).
  - out_pix <= avg[3:2].
  - out_valid <= 1.
  - out_last <= (col==IN_W-1 && row==IN_H-1).
- Latency: out_valid rises the cycle after the producing input beat.
- Output handshake: out_valid & out_ready clears out_valid (and out_last) unless a new output is loaded in the same cycle.
  - Simultaneous drain and new producing beat: the new value is loaded and out_valid stays 1.
  - out_pix/out_last are stable while out_valid=1 and out_ready=0.
- Line buffer: IN_W/2 entries x 5 bits, single write port, single read port. Write and read never collide, because they occur on different row parities.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). The next input beat is treated as (0,0) even without in_sof.
- No output is produced for even-row beats, so out_valid can never rise on consecutive producing beats closer than 2 input beats apart.

Test Plan:
- Uniform frame, all in_pix=15, out_ready=1 -> 256 outputs (IN_W=IN_H=32), all out_pix=3. out_last high only on output #256. Each out_valid pulse is one cycle after every odd-row odd-col beat.
- Rounding blocks, one 2x2 tile each:
  - {0,1,2,3} -> sum 6 -> avg 2 -> out_pix 0.
  - {4,4,4,3} -> sum 15 -> avg 4 -> out_pix 1.
  - {8,8,8,7} -> sum 31 -> avg 8 -> out_pix 2.
  - {15,15,15,14} -> sum 59 -> avg 15 -> out_pix 3.
- Backpressure: hold out_ready=0 after the first output -> in_ready drops the next cycle, and out_pix/out_last are held. Raise out_ready -> one transfer, then in_ready=1. No pixel is lost or duplicated versus the reference model.
- Drain-and-load: out_ready=1 while a producing beat arrives in the same cycle an output drains -> out_valid stays 1, out_pix updates, in_ready never drops.
- Mid-frame in_sof at input row 5 col 9, followed by a full frame of 15s -> exactly 256 further outputs, all 3, with correct out_last. A pending output at the sof instant is delivered.
- Assert rst for 1 cycle mid-row, asynchronously to clk -> out_valid=0 and in_ready=1 immediately. A subsequent full frame without in_sof produces correct outputs starting from (0,0).

Source files
------------

// File: rtl/box_downsampler.sv
// Streaming 2x2 box-filter decimator: 4-bit grey raster in, 2-bit raster out at half size.
// Partial sums of even input rows are kept in a half-width line buffer.
module box_downsampler #(
  parameter int unsigned IN_W = 32,
  parameter int unsigned IN_H = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_pix,
  input  logic       in_sof,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_pix,
  output logic       out_last
);

  localparam int unsigned CW = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int unsigned RW = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int unsigned HW = IN_W / 2;
  localparam int unsigned IW = (HW > 1) ? $clog2(HW) : 1;

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic [3:0]    pair_q;
  logic [4:0]    linebuf [HW];
  logic          beat, store, produce, at_col_end, at_row_end;
  logic [IW-1:0] lb_idx;
  logic [4:0]    lb_rd, pair_sum;
  logic [5:0]    sum_rnd;

  // The output register is single-entry: stall only while it is full and not draining.
  assign in_ready = !(out_valid && !out_ready);
  assign beat     = in_valid && in_ready;

  // in_sof forces the current beat to position (0,0), abandoning any partial frame.
  assign cur_col = in_sof ? '0 : col_q;
  assign cur_row = in_sof ? '0 : row_q;

  assign at_col_end = (cur_col == CW'(IN_W - 1));
  assign at_row_end = (cur_row == RW'(IN_H - 1));
  assign store      = beat && cur_col[0] && !cur_row[0];
  assign produce    = beat && cur_col[0] && cur_row[0];

  assign lb_idx   = IW'(cur_col >> 1);
  assign lb_rd    = linebuf[lb_idx];
  assign pair_sum = {1'b0, pair_q} + {1'b0, in_pix};
  // Adding 2 before dropping the low two bits rounds the 4-pixel mean to nearest.
  assign sum_rnd  = {1'b0, lb_rd} + {1'b0, pair_sum} + 6'd2;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (beat) begin
      if (at_col_end) begin
        col_d = '0;
        row_d = at_row_end ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      pair_q    <= '0;
      out_valid <= 1'b0;
      out_pix   <= '0;
      out_last  <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (beat && !cur_col[0]) begin
        pair_q <= in_pix;
      end
      if (produce) begin
        out_valid <= 1'b1;
        out_pix   <= sum_rnd[5:4];
        out_last  <= at_col_end && at_row_end;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  // Even rows write, odd rows read, so the ports never collide; no reset needed.
  always_ff @(posedge clk) begin
    if (store) begin
      linebuf[lb_idx] <= pair_sum;
    end
  end

endmodule
